uart_rx_ex: RTL and testbench

UART_RX_EX -- requirements
Module: uart_rx_ex

---
 rtl/uart_rx_ex.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_ex.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ex.sv
// uart_rx_ex: oversampling UART receiver with a valid/ready output holding register.
// A 2-flop synchronizer feeds an FSM that samples each bit at mid-bit using a
// CLK_DIVIDE-cycle timing counter. Completed frames, including those with errors,
// are delivered one cycle after the last stop sample. A frame that completes
// while an earlier one is still unaccepted is dropped, and OVERRUN pulses.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the data
// bits, checked as even (PARITY_ODD=0) or odd (PARITY_ODD=1) parity.
module uart_rx_ex #(
    parameter int CLK_DIVIDE = 234,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] RX_DATA_OUT,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN
);

    localparam int CNT_W = $clog2(CLK_DIVIDE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIVIDE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIVIDE / 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    // Reject out-of-range configurations at elaboration time.
    if (CLK_DIVIDE < 4) begin : g_chk_div
        $error("uart_rx_ex: CLK_DIVIDE must be 4 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
        $error("uart_rx_ex: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_rx_ex: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
        $error("uart_rx_ex: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state_reg;
    logic                 rx_meta_reg;
    logic                 rxs_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 stop_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 ferr_reg;
    logic                 done_reg;
`ifdef UART_RX_PARITY_EN
    logic                 par_acc_reg;
    logic                 perr_reg;
`endif

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rxs_reg     <= rx_meta_reg;
        end
    end

    // Receive FSM: bit timing, data shifting, error accumulation, completion pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            ferr_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_reg  <= 1'b0;
            perr_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (!rxs_reg) begin
                        idx_reg   <= '0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (cnt_reg == CNT_HALF) begin
                        cnt_reg <= '0;
                        if (rxs_reg) begin
                            // Glitch shorter than half a bit: ignore it.
                            state_reg <= IDLE;
                        end else begin
                            state_reg    <= DATA;
                            idx_reg      <= '0;
                            stop_idx_reg <= 1'b0;
                            ferr_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            par_acc_reg  <= 1'b0;
                            perr_reg     <= 1'b0;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rxs_reg, shift_reg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                        par_acc_reg <= par_acc_reg ^ rxs_reg;
`endif
                        if (idx_reg == IDX_LAST) begin
                            idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        // XOR over data plus parity bit equals PARITY_ODD when correct.
                        perr_reg  <= ((par_acc_reg ^ rxs_reg) != PARITY_ODD[0]);
                        state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg  <= '0;
                        ferr_reg <= ferr_reg | ~rxs_reg;
                        if (stop_idx_reg == STOP_LAST) begin
                            done_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (ferr_reg || !rxs_reg || perr_reg)
`else
                            if (ferr_reg || !rxs_reg)
`endif
                                state_reg <= WAIT_HIGH;
                            else
                                state_reg <= IDLE;
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must return high before a new start.
                    cnt_reg <= '0;
                    if (rxs_reg)
                        state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RX_DATA_OUT <= '0;
            RX_VALID    <= 1'b0;
            FRAME_ERR   <= 1'b0;
            OVERRUN     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PARITY_ERR  <= 1'b0;
`endif
        end else begin
            OVERRUN <= 1'b0;
            if (done_reg) begin
                if (RX_VALID && !RX_READY) begin
                    // Old frame still unaccepted: keep it, drop the new one.
                    OVERRUN <= 1'b1;
                end else begin
                    RX_DATA_OUT <= shift_reg;
                    FRAME_ERR   <= ferr_reg;
`ifdef UART_RX_PARITY_EN
                    PARITY_ERR  <= perr_reg;
`endif
                    RX_VALID    <= 1'b1;
                end
            end else if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ex.sv
// tb_uart_rx_ex: directed tests for uart_rx_ex at CLK_DIVIDE=16, 8N1
// (8E1 when UART_RX_PARITY_EN is defined).
module tb_uart_rx_ex;

    localparam int CLK_DIV = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX = 1'b1;
    logic       RX_READY = 1'b1;
    logic [7:0] RX_DATA_OUT;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       PARITY_ERR;
    logic       OVERRUN;

    int checks = 0;
    int passed = 0;

    // Monitor results, written only by the monitor process.
    int         valid_cycles = 0;
    int         ovr_pulses = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_ferr = 1'b0;
    logic       last_perr = 1'b0;

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_ex #(
        .CLK_DIVIDE(CLK_DIV),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .PARITY_ODD(0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .RX_DATA_OUT(RX_DATA_OUT),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .FRAME_ERR  (FRAME_ERR),
        .PARITY_ERR (PARITY_ERR),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST) begin
            if (RX_VALID) begin
                valid_cycles <= valid_cycles + 1;
                last_data    <= RX_DATA_OUT;
                last_ferr    <= FRAME_ERR;
                last_perr    <= PARITY_ERR;
            end
            if (OVERRUN)
                ovr_pulses <= ovr_pulses + 1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive one frame LSB first, then idle the line high for two bit times.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_cycles);
        RX = 1'b0;
        wait_cycles(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            wait_cycles(CLK_DIV);
        end
`ifdef UART_RX_PARITY_EN
        RX = (^d) ^ par_flip;
        wait_cycles(CLK_DIV);
`endif
        RX = stop_val;
        wait_cycles(stop_cycles);
        RX = 1'b1;
        wait_cycles(2 * CLK_DIV);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        wait_cycles(3);
        checks++; if (RX_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", RX_VALID); else passed++;
        checks++; if (RX_DATA_OUT !== 8'h00) $display("FAIL reset_data: got %h want 00", RX_DATA_OUT); else passed++;
        checks++; if (FRAME_ERR !== 1'b0) $display("FAIL reset_ferr: got %b want 0", FRAME_ERR); else passed++;
        checks++; if (PARITY_ERR !== 1'b0) $display("FAIL reset_perr: got %b want 0", PARITY_ERR); else passed++;
        checks++; if (OVERRUN !== 1'b0) $display("FAIL reset_ovr: got %b want 0", OVERRUN); else passed++;
        RST = 1'b1;
        wait_cycles(5);
        checks++; if (RX_VALID !== 1'b0) $display("FAIL post_reset_valid: got %b want 0", RX_VALID); else passed++;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int v0, o0;
        RX_READY = 1'b1;
        v0 = valid_cycles; o0 = ovr_pulses;
        send_frame(8'hA5, 1'b1, CLK_DIV);
        checks++; if (valid_cycles - v0 !== 1) $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles - v0); else passed++;
        checks++; if (last_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", last_data); else passed++;
        checks++; if (last_ferr !== 1'b0) $display("FAIL basic_ferr: got %b want 0", last_ferr); else passed++;
        checks++; if (last_perr !== 1'b0) $display("FAIL basic_perr: got %b want 0", last_perr); else passed++;
        checks++; if (ovr_pulses - o0 !== 0) $display("FAIL basic_ovr: got %0d want 0", ovr_pulses - o0); else passed++;
        $display("test_basic: sent a5 got %h", last_data);
    endtask

    task automatic test_false_start();
        int v0;
        v0 = valid_cycles;
        RX = 1'b0;
        wait_cycles(5);
        RX = 1'b1;
        wait_cycles(4 * CLK_DIV);
        checks++; if (valid_cycles - v0 !== 0) $display("FAIL false_start_valid: got %0d want 0", valid_cycles - v0); else passed++;
        // A clean frame right after shows the receiver is back in IDLE.
        send_frame(8'h42, 1'b1, CLK_DIV);
        checks++; if (last_data !== 8'h42) $display("FAIL false_start_next: got %h want 42", last_data); else passed++;
        $display("test_false_start: follow-up frame got %h", last_data);
    endtask

    task automatic test_frame_error();
        int v0;
        v0 = valid_cycles;
        send_frame(8'h3C, 1'b0, 40);
        checks++; if (valid_cycles - v0 !== 1) $display("FAIL ferr_valid_cycles: got %0d want 1", valid_cycles - v0); else passed++;
        checks++; if (last_data !== 8'h3C) $display("FAIL ferr_data: got %h want 3c", last_data); else passed++;
        checks++; if (last_ferr !== 1'b1) $display("FAIL ferr_flag: got %b want 1", last_ferr); else passed++;
        send_frame(8'h81, 1'b1, CLK_DIV);
        checks++; if (last_data !== 8'h81) $display("FAIL ferr_next_data: got %h want 81", last_data); else passed++;
        checks++; if (last_ferr !== 1'b0) $display("FAIL ferr_next_flag: got %b want 0", last_ferr); else passed++;
        $display("test_frame_error: 3c then %h", last_data);
    endtask

    task automatic test_overrun();
        int o0;
        RX_READY = 1'b0;
        o0 = ovr_pulses;
        send_frame(8'h11, 1'b1, CLK_DIV);
        send_frame(8'h22, 1'b1, CLK_DIV);
        checks++; if (RX_VALID !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", RX_VALID); else passed++;
        checks++; if (RX_DATA_OUT !== 8'h11) $display("FAIL ovr_data_kept: got %h want 11", RX_DATA_OUT); else passed++;
        checks++; if (ovr_pulses - o0 !== 1) $display("FAIL ovr_pulses: got %0d want 1", ovr_pulses - o0); else passed++;
        RX_READY = 1'b1;
        wait_cycles(1);
        checks++; if (RX_VALID !== 1'b0) $display("FAIL ovr_valid_clear: got %b want 0", RX_VALID); else passed++;
        $display("test_overrun: held %h", RX_DATA_OUT);
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        logic [7:0] d;
        d = 8'hC3;
        v0 = valid_cycles;
        RX = 1'b0;
        wait_cycles(CLK_DIV);
        for (int i = 0; i < 4; i++) begin
            RX = d[i];
            wait_cycles(CLK_DIV);
        end
        RX = d[4];
        wait_cycles(CLK_DIV / 2);
        RST = 1'b0;
        wait_cycles(3);
        checks++; if (RX_DATA_OUT !== 8'h00) $display("FAIL midrst_data: got %h want 00", RX_DATA_OUT); else passed++;
        RX = 1'b1;
        wait_cycles(2);
        RST = 1'b1;
        wait_cycles(12 * CLK_DIV);
        checks++; if (valid_cycles - v0 !== 0) $display("FAIL midrst_no_output: got %0d want 0", valid_cycles - v0); else passed++;
        send_frame(8'h5A, 1'b1, CLK_DIV);
        checks++; if (valid_cycles - v0 !== 1) $display("FAIL midrst_next_valid: got %0d want 1", valid_cycles - v0); else passed++;
        checks++; if (last_data !== 8'h5A) $display("FAIL midrst_next_data: got %h want 5a", last_data); else passed++;
        $display("test_reset_mid_frame: got %h", last_data);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        // 0x07 has three ones: even parity bit must be 1.
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, CLK_DIV);
        checks++; if (last_data !== 8'h07) $display("FAIL par_bad_data: got %h want 07", last_data); else passed++;
        checks++; if (last_perr !== 1'b1) $display("FAIL par_bad_flag: got %b want 1", last_perr); else passed++;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, CLK_DIV);
        checks++; if (last_perr !== 1'b0) $display("FAIL par_good_flag: got %b want 0", last_perr); else passed++;
        $display("test_parity: done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
